rambus_arbiter: RTL
===================

Name: rambus_arbiter

Overview:
- Round-robin arbiter sharing the single shared-OpenRAM wishbone port (rambus) between NUM_REQ wishbone-classic masters.
- Typical masters: generator sample fetcher and Caravel-side table loader.
- Sits between the requesters and the rambus_wb_* pins of the wrapped project; grants one master per transaction and routes ack/data back to it only.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..4)
- ADDR_W, 8, rambus address width
- DATA_W, 32, data width; sel width = DATA_W/8
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_cyc_i  in  NUM_REQ  per-master cycle
- req_stb_i  in  NUM_REQ  per-master strobe
- req_we_i  in  NUM_REQ  per-master write enable
- req_sel_i  in  NUM_REQ*DATA_W/8  packed byte selects, master i at slice i
- req_adr_i  in  NUM_REQ*ADDR_W  packed addresses
- req_dat_i  in  NUM_REQ*DATA_W  packed write data
- req_ack_o  out  NUM_REQ  ack to granted master only
- req_err_o  out  NUM_REQ  timeout error; tied 0 when the feature is off
- req_dat_o  out  DATA_W  read data, broadcast to all masters (valid only with own ack)
- grant_o  out  NUM_REQ  one-hot current grant, status
- rambus_wb_clk_o  out  1  = wb_clk_i
- rambus_wb_rst_o  out  1  = wb_rst_i
- rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o  out  1 each  from granted master, gated by grant
- rambus_wb_sel_o  out  DATA_W/8;  rambus_wb_adr_o  out  ADDR_W;  rambus_wb_dat_o  out  DATA_W
- rambus_wb_ack_i  in  1;  rambus_wb_dat_i  in  DATA_W

Behaviour:
- Reset (async, wb_rst_i=1): state IDLE; grant_o=0; rr pointer=0; all rambus_* control and data outputs 0; req_ack_o=0; req_err_o=0. Reset mid-transaction aborts immediately with no ack.
- FSM states:
  - IDLE: if any req_cyc_i&req_stb_i, choose the first requester at or after rr pointer (wrapping modulo NUM_REQ); register one-hot grant; go BUSY. No request: stay IDLE.
  - BUSY: rambus outputs combinationally mux the granted master's signals; all others are ignored.
    - rambus_wb_ack_i → req_ack_o[g]=1 the same cycle.
    - When the granted req_cyc_i drops: clear grant, rr pointer=g+1 (wrap), go IDLE.
- Latency: request at cycle N → grant and rambus_wb_cyc_o at N+1. At least one IDLE cycle separates consecutive grants.
- Simultaneous requests are resolved only by the rr pointer. A new request arriving in BUSY waits.
- A master may hold cyc over several stb/ack beats; grant persists until cyc drops.
- Acks with no grant are ignored. req_ack_o is never asserted to a non-granted master.
- A master that drops stb but holds cyc keeps the grant; rambus_wb_stb_o follows it.

Optional Feature:
- Macro RAMBUS_ARB_TIMEOUT_EN.
- Defined: an 8+ bit watchdog counts BUSY cycles with stb high and no ack. It clears on ack.
  - On reaching TIMEOUT_CYC: pulse req_err_o[g] for 1 cycle, force rambus cyc/stb low, go to DRAIN.
  - DRAIN: stays until the master drops cyc, then clears the grant, advances rr and returns to IDLE.
- Undefined: no counter, no DRAIN state, req_err_o tied 0; the arbiter waits indefinitely for ack.

Decomposition:
- Shared package rambus_arb_pkg: state encoding (IDLE, BUSY, DRAIN), default widths, and the rr-pick function (first set bit from pointer, modulo wrap).
- Sub-module rr_picker (request vector + pointer → one-hot), reused by later arbiters.

Test Plan:
- Reset check: assert wb_rst_i mid-BUSY → same cycle grant_o=0, rambus_wb_cyc_o=0, no ack on either master.
- Single master: m0 reads adr 0x10, RAM acks after 2 cycles with 0xDEADBEEF → req_ack_o=01, req_dat_o=0xDEADBEEF; rambus_wb_cyc_o high from cycle N+1.
- Contention: m0 and m1 both request at cycle 0 after reset → m0 granted first. Both re-request continuously → grants alternate 01,10,01,10 with an IDLE cycle between each.
- Multi-beat: m1 holds cyc for 3 writes (adr 0x20..0x22, sel 0xF) while m0 requests → m0 waits; grant_o stays 10 until m1 drops cyc.
- Isolation: m0 granted; rambus_wb_ack_i pulses → only req_ack_o[0] asserts. Stray ack while IDLE → no req_ack_o.
- With RAMBUS_ARB_TIMEOUT_EN and TIMEOUT_CYC=4: RAM never acks → req_err_o[0] pulses at cycle 4 of stb; rambus_wb_cyc_o drops; m1 is granted after m0 releases cyc.

Source files
------------

// File: rtl/rambus_arb_pkg.sv
// rambus arbiter shared definitions
// FSM encoding, default widths and the round-robin pick helper
package rambus_arb_pkg;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;
    localparam int MAX_REQ         = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Returns {found, index} of the first set request at or after ptr,
    // wrapping modulo n (n = number of live requesters).
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [1:0]         ptr,
        input int unsigned        n
    );
        logic       found;
        logic [1:0] idx;
        logic [1:0] sel;
        found = 1'b0;
        sel   = 2'd0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 2'((32'(ptr) + k) % n);
            if (k < n && !found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

endpackage

// File: rtl/rambus_arbiter_rr_picker.sv
// rr_picker: request vector + rotating pointer -> one-hot winner
// Combinational; a zero request vector yields a zero grant.
module rr_picker
    import rambus_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0] req_i,
    input  logic [1:0]   ptr_i,
    output logic [N-1:0] gnt_o
);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         pick;

    // Widen to the helper's fixed width, pick, then expand to one-hot
    always_comb begin
        req_ext = '0;
        req_ext[N-1:0] = req_i;
        pick = rr_pick(req_ext, ptr_i, N);
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = pick[2] && (pick[1:0] == 2'(i));
        end
    end

endmodule

// File: rtl/rambus_arbiter.sv
// rambus_arbiter: round-robin share of the rambus wishbone port
// Optional ack watchdog with DRAIN state: `define RAMBUS_ARB_TIMEOUT_EN
module rambus_arbiter
    import rambus_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic [NUM_REQ-1:0]           req_cyc_i,
    input  logic [NUM_REQ-1:0]           req_stb_i,
    input  logic [NUM_REQ-1:0]           req_we_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_sel_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_adr_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_dat_i,
    output logic [NUM_REQ-1:0]           req_ack_o,
    output logic [NUM_REQ-1:0]           req_err_o,
    output logic [DATA_W-1:0]            req_dat_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         rambus_wb_clk_o,
    output logic                         rambus_wb_rst_o,
    output logic                         rambus_wb_cyc_o,
    output logic                         rambus_wb_stb_o,
    output logic                         rambus_wb_we_o,
    output logic [DATA_W/8-1:0]          rambus_wb_sel_o,
    output logic [ADDR_W-1:0]            rambus_wb_adr_o,
    output logic [DATA_W-1:0]            rambus_wb_dat_o,
    input  logic                         rambus_wb_ack_i,
    input  logic [DATA_W-1:0]            rambus_wb_dat_i
);

    localparam int SEL_W = DATA_W / 8;

    logic [1:0]         state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] req_vld, pick;
    logic [1:0]         gidx, next_ptr;
    logic               busy;
    logic               g_cyc, g_stb, g_we;
    logic [SEL_W-1:0]   g_sel;
    logic [ADDR_W-1:0]  g_adr;
    logic [DATA_W-1:0]  g_dat;

    assign req_vld = req_cyc_i & req_stb_i;

    rr_picker #(.N(NUM_REQ)) u_rr_picker (
        .req_i (req_vld),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // AND-OR mux of the owner's bus signals, plus its index
    always_comb begin
        gidx  = '0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) gidx = 2'(i);
            g_cyc |= grant_q[i] & req_cyc_i[i];
            g_stb |= grant_q[i] & req_stb_i[i];
            g_we  |= grant_q[i] & req_we_i[i];
            g_sel |= {SEL_W{grant_q[i]}}
                   & req_sel_i[i*SEL_W +: SEL_W];
            g_adr |= {ADDR_W{grant_q[i]}}
                   & req_adr_i[i*ADDR_W +: ADDR_W];
            g_dat |= {DATA_W{grant_q[i]}}
                   & req_dat_i[i*DATA_W +: DATA_W];
        end
    end

    assign busy     = (state_q == ST_BUSY);
    assign next_ptr = (gidx == 2'(NUM_REQ - 1)) ? 2'd0 : gidx + 2'd1;

    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = wb_rst_i;
    assign rambus_wb_cyc_o = busy & g_cyc;
    assign rambus_wb_stb_o = busy & g_stb;
    assign rambus_wb_we_o  = busy & g_we;
    assign rambus_wb_sel_o = busy ? g_sel : '0;
    assign rambus_wb_adr_o = busy ? g_adr : '0;
    assign rambus_wb_dat_o = busy ? g_dat : '0;

    assign req_ack_o = (busy && rambus_wb_ack_i) ? grant_q : '0;
    assign req_dat_o = rambus_wb_dat_i;
    assign grant_o   = grant_q;

`ifdef RAMBUS_ARB_TIMEOUT_EN
    localparam int WD_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int WD_W   = (WD_RAW < 8) ? 8 : WD_RAW;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_hit;

    // Count owner strobe cycles left unanswered; ack restarts the count
    always_comb begin
        wd_d   = wd_q;
        wd_hit = busy && g_stb && !rambus_wb_ack_i
              && (wd_q == WD_W'(TIMEOUT_CYC - 1));
        if (!busy || rambus_wb_ack_i) begin
            wd_d = '0;
        end else if (g_stb) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Watchdog register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) wd_q <= '0;
        else          wd_q <= wd_d;
    end

    assign req_err_o = wd_hit ? grant_q : '0;
`else
    assign req_err_o = '0;
`endif

    // Grant FSM: pick in IDLE, hold while owner keeps cyc
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    grant_d = pick;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!g_cyc) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = ST_IDLE;
                end
`ifdef RAMBUS_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    state_d = ST_DRAIN;
                end
`endif
            end
`ifdef RAMBUS_ARB_TIMEOUT_EN
            ST_DRAIN: begin
                if (!g_cyc) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and pointer registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
